pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised valid/ready pipeline register placed between RV32I pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces bulk per-field non-blocking copies between stage bundles with a handshaked buffer.
//  Adds back-pressure (stall), flush (bubble insertion) and an optional skid entry for full throughput with registered ready.
//  Also counts downstream stall cycles.
// PARAMETERS
//  DATA_W  32  payload width in bits (packed stage struct from core_pipe_pkg)
//  SKID    1   1: two-entry skid buffer, up_ready registered; 0: single entry, up_ready combinational
//  PERF_W  16  width of the stall cycle counter
// PORTS
//  clk        in   1       core clock; all state updates on rising edge
//  reset      in   1       synchronous, active-low reset
//  flush      in   1       kill all held entries (branch/jump redirect)
//  up_valid   in   1       upstream stage presents payload
//  up_ready   out  1       buffer accepts payload this cycle
//  up_data    in   DATA_W  upstream payload
//  dn_valid   out  1       payload available to downstream stage
//  dn_ready   in   1       downstream consumes payload this cycle (0 = stall)
//  dn_data    out  DATA_W  downstream payload
//  occupancy  out  2       held entries: 0, 1 or 2 (2 only when SKID=1)
//  stall_cnt  out  PERF_W  cycles with dn_valid=1 and dn_ready=0
// BEHAVIOUR
//  One clock; reset is synchronous and active-low.
//  Reset (reset=0 at a clock edge):
//   - Outputs after that edge: dn_valid=0, dn_data=0, occupancy=0, stall_cnt=0, state ST_EMPTY.
//   - up_ready is 0 while reset=0. Any up_valid presented then is ignored.
//   - Reset asserted mid-transfer discards all held entries.
//  Transfer rules:
//   - Push when up_valid and up_ready. Pop when dn_valid and dn_ready.
//   - Order is strictly FIFO. Nothing is duplicated or dropped except on flush.
//   - dn_valid and dn_data stay stable while dn_valid=1 and dn_ready=0.
//   - dn_valid never depends combinationally on dn_ready.
//  SKID=1 FSM (core_pipe_pkg::pipe_st_e):
//   - ST_EMPTY: push -> ST_BUSY (main entry loaded).
//   - ST_BUSY: push without pop -> ST_FULL (skid entry loaded). Pop without push -> ST_EMPTY. Push with pop -> ST_BUSY (main reloaded).
//   - ST_FULL: pop -> ST_BUSY (skid moves to main; a push is impossible because up_ready=0).
//   - up_ready is a flop: 1 in ST_EMPTY and ST_BUSY, 0 in ST_FULL.
//   - Latency: payload pushed at edge N is on dn_data after edge N (1 cycle).
//   - Throughput: 1 transfer per cycle with dn_ready held at 1.
//  SKID=0:
//   - Single entry with states ST_EMPTY and ST_BUSY only.
//   - up_ready = reset & (!dn_valid | dn_ready). Push and pop in the same cycle are allowed.
//  Flush:
//   - Priority: reset > flush > push/pop.
//   - flush=1 at an edge -> ST_EMPTY, dn_valid=0, occupancy=0.
//   - A push in the flush cycle is discarded. A pop in the flush cycle still completes downstream.
//   - dn_data keeps its last value after flush. Only the valid bit is cleared.
//  stall_cnt:
//   - Increments when dn_valid & !dn_ready. Saturates at all-ones and does not wrap.
//   - Unaffected by flush. Cleared only by reset.
//  occupancy is registered and matches the state: EMPTY=0, BUSY=1, FULL=2.
// STRUCTURE
//  core_pipe_pkg holds:
//   - typedef enum logic [1:0] pipe_st_e {ST_EMPTY, ST_BUSY, ST_FULL}.
//   - Packed stage payload structs: if_id_t, id_ex_t, ex_mem_t, mem_wb_t.
//   - Constant PIPE_NOP_INSTR = 32'h0000_0013 (addi x0,x0,0).
//  One sub-module: sat_counter #(W) for stall_cnt (inc enable, sync active-low clear, saturate).
//  Skid datapath and FSM stay in this module, with generate on SKID.
//  Assertions: no push when up_ready=0 is recorded; dn_data stable under stall; occupancy <= 1 when SKID=0.
// TESTING
//  1. Reset: hold reset=0 for 3 cycles with up_valid=1 -> up_ready=0, dn_valid=0, occupancy=0, stall_cnt=0; after release up_ready=1.
//  2. Streaming, SKID=1, dn_ready=1: push 32'h1,2,3... every cycle -> dn_data equals the same sequence one cycle later; never a bubble; occupancy stays 1.
//  3. Back-pressure, SKID=1: push A,B,C with dn_ready=0 -> after B occupancy=2, up_ready=0, C is held upstream. Raise dn_ready -> output order A,B,C; stall_cnt equals the stalled cycle count.
//  4. Flush: occupancy=2 plus push D with flush=1 -> next cycle dn_valid=0, occupancy=0, D never appears downstream.
//  5. Saturation, PERF_W=4: dn_ready=0 with a held entry for 20 cycles -> stall_cnt stops at 4'hF.
//  6. SKID=0: dn_ready toggles 1,0,1 with continuous push -> up_ready follows !dn_valid|dn_ready combinationally; FIFO order intact; occupancy never exceeds 1.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// rtl/core_pipe_pkg.sv - shared pipeline types, stage payloads and buffer state encoding
package core_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_st_e;

    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    function automatic logic [1:0] occ_of(input pipe_st_e st);
        case (st)
            ST_BUSY: occ_of = 2'd1;
            ST_FULL: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - handshaked pipeline register with optional skid entry, flush and stall counter
module pipe_stage_buf
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    output logic [PERF_W-1:0] stall_cnt
);

    pipe_st_e          st_q, st_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_data;
    logic              push, pop;
    logic              load_main, load_skid;

    assign push = up_valid & up_ready;
    assign pop  = dn_valid & dn_ready;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            st_q <= ST_EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_EMPTY: if (push) st_d = ST_BUSY;
            ST_BUSY: begin
                if (push && !pop) begin
                    st_d = (SKID != 0) ? ST_FULL : ST_BUSY;
                end else if (!push && pop) begin
                    st_d = ST_EMPTY;
                end
            end
            ST_FULL:  if (pop) st_d = ST_BUSY;
            default:  st_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        dn_valid  = (st_q != ST_EMPTY);
        occupancy = occ_of(st_q);
    end

    // Main is refilled from upstream on any accepted push it can absorb, or from skid when draining FULL
    assign load_main = !flush && ((push && ((st_q == ST_EMPTY) || pop)) || ((st_q == ST_FULL) && pop));
    assign load_skid = !flush && push && (st_q == ST_BUSY) && !pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= (st_q == ST_FULL) ? skid_data : up_data;
        end
    end

    assign dn_data = main_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;

            // Ready decodes straight from the state flop, so it never sees dn_ready
            assign up_ready = reset & (st_q != ST_FULL);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    skid_q <= '0;
                end else if (load_skid) begin
                    skid_q <= up_data;
                end
            end

            assign skid_data = skid_q;
        end else begin : g_single
            assign up_ready  = reset & (!dn_valid | dn_ready);
            assign skid_data = '0;

            a_single_occ: assert property (@(posedge clk) disable iff (!reset)
                occupancy <= 2'd1);
        end
    endgenerate

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (dn_valid & !dn_ready),
        .count (stall_cnt)
    );

    a_no_push_unready: assert property (@(posedge clk) disable iff (!reset)
        ((load_main && (st_q != ST_FULL)) || load_skid) |-> up_ready);

    a_stall_stable: assert property (@(posedge clk) disable iff (!reset)
        (dn_valid && !dn_ready && !flush) |=> (dn_valid && $stable(dn_data)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf (skid and single-entry builds)
module tb_pipe_stage_buf;

    logic        clk;
    logic        reset;

    logic        s_flush, s_up_valid, s_up_ready, s_dn_valid, s_dn_ready;
    logic [31:0] s_up_data, s_dn_data;
    logic [1:0]  s_occ;
    logic [3:0]  s_stall;

    logic        n_flush, n_up_valid, n_up_ready, n_dn_valid, n_dn_ready;
    logic [31:0] n_up_data, n_dn_data;
    logic [1:0]  n_occ;
    logic [15:0] n_stall;

    int total = 0;
    int bad   = 0;

    pipe_stage_buf #(.DATA_W(32), .SKID(1), .PERF_W(4)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (s_flush),
        .up_valid  (s_up_valid),
        .up_ready  (s_up_ready),
        .up_data   (s_up_data),
        .dn_valid  (s_dn_valid),
        .dn_ready  (s_dn_ready),
        .dn_data   (s_dn_data),
        .occupancy (s_occ),
        .stall_cnt (s_stall)
    );

    pipe_stage_buf #(.DATA_W(32), .SKID(0), .PERF_W(16)) u_single (
        .clk       (clk),
        .reset     (reset),
        .flush     (n_flush),
        .up_valid  (n_up_valid),
        .up_ready  (n_up_ready),
        .up_data   (n_up_data),
        .dn_valid  (n_dn_valid),
        .dn_ready  (n_dn_ready),
        .dn_data   (n_dn_data),
        .occupancy (n_occ),
        .stall_cnt (n_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        s_flush    = 1'b0; s_up_valid = 1'b1; s_up_data = 32'hAA; s_dn_ready = 1'b0;
        n_flush    = 1'b0; n_up_valid = 1'b1; n_up_data = 32'hBB; n_dn_ready = 1'b0;

        // reset held with upstream offering data
        tick(); tick(); tick();
        chk("rst_s_up_ready", 32'(s_up_ready), 0);
        chk("rst_s_dn_valid", 32'(s_dn_valid), 0);
        chk("rst_s_dn_data", s_dn_data, 0);
        chk("rst_s_occ", 32'(s_occ), 0);
        chk("rst_s_stall", 32'(s_stall), 0);
        chk("rst_n_up_ready", 32'(n_up_ready), 0);
        chk("rst_n_dn_valid", 32'(n_dn_valid), 0);
        s_up_valid = 1'b0;
        n_up_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_s_up_ready", 32'(s_up_ready), 1);
        chk("rel_n_up_ready", 32'(n_up_ready), 1);

        // streaming through the skid build
        s_dn_ready = 1'b1;
        s_up_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            s_up_data = 32'(i);
            tick();
            chk("stream_valid", 32'(s_dn_valid), 1);
            chk("stream_data", s_dn_data, 32'(i));
            chk("stream_occ", 32'(s_occ), 1);
        end
        s_up_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 32'(s_dn_valid), 0);
        chk("stream_stall", 32'(s_stall), 0);

        // back-pressure fills the skid entry
        s_dn_ready = 1'b0;
        s_up_valid = 1'b1; s_up_data = 32'hA;
        tick();
        chk("bp_a_data", s_dn_data, 32'hA);
        chk("bp_a_occ", 32'(s_occ), 1);
        s_up_data = 32'hB;
        tick();
        chk("bp_b_occ", 32'(s_occ), 2);
        chk("bp_b_up_ready", 32'(s_up_ready), 0);
        chk("bp_b_data", s_dn_data, 32'hA);
        s_up_data = 32'hC;
        tick();
        chk("bp_c_occ", 32'(s_occ), 2);
        chk("bp_c_data", s_dn_data, 32'hA);
        s_dn_ready = 1'b1;
        tick();
        chk("bp_out_b", s_dn_data, 32'hB);
        chk("bp_out_b_occ", 32'(s_occ), 1);
        chk("bp_out_b_ready", 32'(s_up_ready), 1);
        tick();
        chk("bp_out_c", s_dn_data, 32'hC);
        chk("bp_out_c_occ", 32'(s_occ), 1);
        s_up_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 32'(s_dn_valid), 0);
        chk("bp_stall", 32'(s_stall), 2);

        // flush while full, with a push in the same cycle
        s_dn_ready = 1'b0;
        s_up_valid = 1'b1; s_up_data = 32'h11;
        tick();
        s_up_data = 32'h22;
        tick();
        chk("fl_pre_occ", 32'(s_occ), 2);
        s_up_data = 32'hDD; s_flush = 1'b1;
        tick();
        chk("fl_valid", 32'(s_dn_valid), 0);
        chk("fl_occ", 32'(s_occ), 0);
        chk("fl_data_kept", s_dn_data, 32'h11);
        chk("fl_stall", 32'(s_stall), 4);
        chk("fl_up_ready", 32'(s_up_ready), 1);
        s_flush = 1'b0; s_up_valid = 1'b0; s_dn_ready = 1'b1;
        tick();
        chk("fl_no_d_valid", 32'(s_dn_valid), 0);
        s_up_valid = 1'b1; s_up_data = 32'h33;
        tick();
        chk("fl_after_data", s_dn_data, 32'h33);
        s_up_valid = 1'b0;
        tick();
        chk("fl_after_drain", 32'(s_dn_valid), 0);

        // saturation of the 4-bit stall counter
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("sat_cleared", 32'(s_stall), 0);
        s_dn_ready = 1'b0;
        s_up_valid = 1'b1; s_up_data = 32'h55;
        tick();
        s_up_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid", 32'(s_stall), 32'hA);
        for (int i = 0; i < 10; i++) tick();
        chk("sat_top", 32'(s_stall), 32'hF);
        chk("sat_data", s_dn_data, 32'h55);
        s_dn_ready = 1'b1;
        tick();
        chk("sat_hold", 32'(s_stall), 32'hF);
        chk("sat_drain", 32'(s_dn_valid), 0);

        // single-entry build: combinational ready follows dn_ready
        n_dn_ready = 1'b1;
        n_up_valid = 1'b1; n_up_data = 32'h101;
        #1;
        chk("se_ready_empty", 32'(n_up_ready), 1);
        tick();
        chk("se_data_1", n_dn_data, 32'h101);
        chk("se_occ_1", 32'(n_occ), 1);
        n_up_data = 32'h102;
        #1;
        chk("se_ready_pop", 32'(n_up_ready), 1);
        tick();
        chk("se_data_2", n_dn_data, 32'h102);
        n_dn_ready = 1'b0; n_up_data = 32'h103;
        #1;
        chk("se_ready_stall", 32'(n_up_ready), 0);
        tick();
        chk("se_data_held", n_dn_data, 32'h102);
        chk("se_occ_held", 32'(n_occ), 1);
        chk("se_stall", 32'(n_stall), 1);
        n_dn_ready = 1'b1;
        #1;
        chk("se_ready_resume", 32'(n_up_ready), 1);
        tick();
        chk("se_data_3", n_dn_data, 32'h103);
        chk("se_occ_3", 32'(n_occ), 1);
        n_up_valid = 1'b0;
        tick();
        chk("se_drain_valid", 32'(n_dn_valid), 0);
        chk("se_drain_occ", 32'(n_occ), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
